// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the LSU load-side blocks.
//   ld_arb_st_e    : load read-arbiter FSM states
//   AXI_SIZE_8B    : AXI arsize for 8-byte beats
//   AXI_BURST_INCR : AXI incrementing burst type
//   RAM_SEL_*      : on-chip RAM select encoding (IRAM = 0, WRAM = 1)
package lsu_pkg;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_AR   = 2'd1,
    LD_RD   = 2'd2,
    LD_DONE = 2'd3
  } ld_arb_st_e;

  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic       RAM_SEL_IRAM   = 1'b0;
  localparam logic       RAM_SEL_WRAM   = 1'b1;

endpackage

// File: rtl/lsu_rr_arb2.sv
// lsu_rr_arb2: two-way round-robin arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   i_vld0/1   : request valids (0 = IRAM, 1 = WRAM)
//   i_accept   : the current grant was taken; pointer moves past the winner
//   o_gnt_vld  : some requester is granted
//   o_gnt_sel  : index of the granted requester
module lsu_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_vld0,
  input  logic i_vld1,
  input  logic i_accept,
  output logic o_gnt_vld,
  output logic o_gnt_sel
);

  logic r_ptr;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    o_gnt_vld = i_vld0 | i_vld1;
    o_gnt_sel = (i_vld0 & i_vld1) ? r_ptr : i_vld1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_accept) begin
      r_ptr <= ~o_gnt_sel;
    end
  end

endmodule

// File: rtl/lsu_ld_rd_arb.sv
// lsu_ld_rd_arb: shares the LSU AXI read channel between IRAM-fill and
// WRAM-fill load requesters, one burst outstanding at a time.
//   iram_req_* / wram_req_* : load requests (vld/rdy, DRAM addr, beats-1, RAM addr)
//   lsu_axi_ar* / axi_lsu_arrdy : AXI read-address channel
//   axi_lsu_r* / lsu_axi_rrdy   : AXI read-data channel
//   ram_wr_*   : write port toward the selected on-chip RAM (driven from R)
//   ld_done_*  : one-cycle completion pulse with requester and error flag
module lsu_ld_rd_arb
  import lsu_pkg::*;
#(
  parameter int         DADDR_W = 10,
  parameter int         RADDR_W = 12,
  parameter int         DATA_W  = 64,
  parameter logic [7:0] ID_BASE = 8'h10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iram_req_vld,
  output logic               iram_req_rdy,
  input  logic [DADDR_W-1:0] iram_req_daddr,
  input  logic [7:0]         iram_req_len,
  input  logic [RADDR_W-1:0] iram_req_raddr,
  input  logic               wram_req_vld,
  output logic               wram_req_rdy,
  input  logic [DADDR_W-1:0] wram_req_daddr,
  input  logic [7:0]         wram_req_len,
  input  logic [RADDR_W-1:0] wram_req_raddr,
  output logic [7:0]         lsu_axi_arid,
  output logic [DADDR_W-1:0] lsu_axi_araddr,
  output logic [7:0]         lsu_axi_arlen,
  output logic [2:0]         lsu_axi_arsize,
  output logic [1:0]         lsu_axi_arburst,
  output logic               lsu_axi_arvld,
  input  logic               axi_lsu_arrdy,
  input  logic [7:0]         axi_lsu_rid,
  input  logic [DATA_W-1:0]  axi_lsu_rdata,
  input  logic [1:0]         axi_lsu_rresp,
  input  logic               axi_lsu_rlast,
  input  logic               axi_lsu_rvld,
  output logic               lsu_axi_rrdy,
  output logic               ram_wr_vld,
  output logic               ram_wr_sel,
  output logic [RADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0]  ram_wr_data,
  output logic               ld_done_vld,
  output logic               ld_done_sel,
  output logic               ld_done_err
);

  ld_arb_st_e         r_st;
  ld_arb_st_e         w_st_nxt;
  logic               r_sel;
  logic [RADDR_W-1:0] r_raddr;
  logic [8:0]         r_beat_cnt;
  logic               r_err;
  logic [7:0]         r_arid;
  logic [DADDR_W-1:0] r_araddr;
  logic [7:0]         r_arlen;

  logic               w_gnt_vld;
  logic               w_gnt_sel;
  logic               w_req_hs;
  logic [DADDR_W-1:0] w_req_daddr;
  logic [7:0]         w_req_len;
  logic [RADDR_W-1:0] w_req_raddr;
  logic               w_rd;
  logic               w_beat;
  logic               w_id_ok;
  logic               w_in_rng;
  logic               w_wr;
  logic               w_beat_err;

  lsu_rr_arb2 u_rr_arb (
    .clk       (clk),
    .rst       (rst),
    .i_vld0    (iram_req_vld),
    .i_vld1    (wram_req_vld),
    .i_accept  (w_req_hs),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_sel (w_gnt_sel)
  );

  // Request side: rdy only in IDLE and never while reset is held, so a
  // request cannot be swallowed during reset.
  always_comb begin
    w_req_hs     = (r_st == LD_IDLE) & ~rst & w_gnt_vld;
    iram_req_rdy = w_req_hs & (w_gnt_sel == RAM_SEL_IRAM);
    wram_req_rdy = w_req_hs & (w_gnt_sel == RAM_SEL_WRAM);
    w_req_daddr  = w_gnt_sel ? wram_req_daddr : iram_req_daddr;
    w_req_len    = w_gnt_sel ? wram_req_len   : iram_req_len;
    w_req_raddr  = w_gnt_sel ? wram_req_raddr : iram_req_raddr;
  end

  // Beat qualification. A beat with a foreign id or past the programmed
  // length is consumed but not written; every anomaly sets the sticky error.
  always_comb begin
    w_rd       = (r_st == LD_RD);
    w_beat     = w_rd & axi_lsu_rvld;
    w_id_ok    = (axi_lsu_rid == r_arid);
    w_in_rng   = (r_beat_cnt <= {1'b0, r_arlen});
    w_wr       = w_beat & w_id_ok & w_in_rng;
    w_beat_err = w_beat & ((axi_lsu_rresp != 2'b00) | ~w_id_ok | ~w_in_rng |
                           (axi_lsu_rlast & (r_beat_cnt != {1'b0, r_arlen})));
  end

  always_comb begin
    lsu_axi_arid    = r_arid;
    lsu_axi_araddr  = r_araddr;
    lsu_axi_arlen   = r_arlen;
    lsu_axi_arsize  = AXI_SIZE_8B;
    lsu_axi_arburst = AXI_BURST_INCR;
    lsu_axi_arvld   = (r_st == LD_AR);
    lsu_axi_rrdy    = w_rd;
    ram_wr_vld      = w_wr;
    ram_wr_sel      = w_wr & (r_sel == RAM_SEL_WRAM);
    ram_wr_addr     = w_wr ? (r_raddr + RADDR_W'(r_beat_cnt)) : '0;
    ram_wr_data     = w_wr ? axi_lsu_rdata : '0;
    ld_done_vld     = (r_st == LD_DONE);
    ld_done_sel     = (r_st == LD_DONE) & r_sel;
    ld_done_err     = (r_st == LD_DONE) & r_err;
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      LD_IDLE: if (w_req_hs) w_st_nxt = LD_AR;
      LD_AR:   if (axi_lsu_arrdy) w_st_nxt = LD_RD;
      // Only rlast ends a burst, even when it arrives early or late.
      LD_RD:   if (w_beat & axi_lsu_rlast) w_st_nxt = LD_DONE;
      LD_DONE: w_st_nxt = LD_IDLE;
      default: w_st_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st       <= LD_IDLE;
      r_sel      <= 1'b0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
      r_arid     <= '0;
      r_araddr   <= '0;
      r_arlen    <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (w_req_hs) begin
        r_sel    <= w_gnt_sel;
        r_arid   <= ID_BASE | {7'b0, w_gnt_sel};
        r_araddr <= w_req_daddr;
        r_arlen  <= w_req_len;
      end
      if ((r_st == LD_AR) && axi_lsu_arrdy) begin
        r_beat_cnt <= '0;
        r_err      <= 1'b0;
      end else if (w_beat) begin
        r_err <= r_err | w_beat_err;
        // Foreign-id beats are not part of this burst; saturate so a runaway
        // slave cannot wrap the count back into range.
        if (w_id_ok && (r_beat_cnt != 9'h1FF)) r_beat_cnt <= r_beat_cnt + 9'd1;
      end
    end
  end

  // RAM base address is pure datapath; it is only observed through gated outputs.
  always_ff @(posedge clk) begin
    if (w_req_hs) r_raddr <= w_req_raddr;
  end

endmodule
